// File: rtl/pmu_pkt_deserializer.sv
// pmu_pkt_deserializer
//   Turns the JTAG Shift-DR bit stream (TDI, LSB-first) into PMU commands.
//   A 32-bit header carries the command (hdr[3:0]) and the payload length in
//   bits (hdr[8 +: LEN_W]). A zero length with a non-zero command means one
//   full BLOCK_W-bit block. The payload is packed into BLOCK_W-bit blocks and
//   queued in a DEPTH-entry FIFO. The final block is zero-padded above its
//   valid-bit count.
//
// Optional feature: define PMU_PKT_CRC_EN to receive a 32-bit CRC-32 trailer
//   after the payload and flag a mismatch on crc_err_o. When the macro is not
//   defined there is no CRC state or logic, and crc_err_o is tied to 0.
//
// Handshake: the head block transfers on any rising edge where blk_valid_o
//   and blk_ready_i are both high. blk_valid_o never depends on blk_ready_i.
//   blk_data_o, blk_bits_o and blk_last_o are stable while blk_valid_o is
//   high and no transfer has taken place.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   shift_en_i, tdi_i       serial bit strobe and data
//   abort_i                 discard the packet in flight
//   cmd_o, len_o            last decoded header fields
//   cmd_valid_o             one-cycle pulse after header bit 31
//   blk_*                   FIFO head block and handshake
//   busy_o                  packet in flight or FIFO non-empty
//   done_o                  one-cycle pulse after the last block is popped
//   overflow_o, crc_err_o   sticky flags, cleared when a new header starts
//   state_o                 FSM state (0 idle, 1 header, 2 payload, 3 crc)
module pmu_pkt_deserializer #(
   parameter int BLOCK_W = 128,
   parameter int DEPTH   = 2,
   parameter int LEN_W   = 24
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        shift_en_i,
   input  logic                        tdi_i,
   input  logic                        abort_i,
   output logic [3:0]                  cmd_o,
   output logic [LEN_W-1:0]            len_o,
   output logic                        cmd_valid_o,
   output logic [BLOCK_W-1:0]          blk_data_o,
   output logic                        blk_valid_o,
   input  logic                        blk_ready_i,
   output logic                        blk_last_o,
   output logic [$clog2(BLOCK_W):0]    blk_bits_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        overflow_o,
   output logic                        crc_err_o,
   output logic [1:0]                  state_o
);

   localparam int IDX_W  = $clog2(BLOCK_W);
   localparam int BITS_W = IDX_W + 1;
   localparam int TOT_W  = LEN_W + 1;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2
`ifdef PMU_PKT_CRC_EN
      , ST_CRC = 2'd3
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [31:0]           hdr_q;        // header shifter, reused for the CRC trailer
   logic [4:0]            hdr_cnt_q;
   logic [3:0]            cmd_q;
   logic [LEN_W-1:0]      len_q;
   logic                  cmd_valid_q;
   logic [TOT_W-1:0]      pay_len_q;    // effective payload length in bits
   logic [TOT_W-1:0]      total_q;
   logic [BLOCK_W-1:0]    blk_q;
   logic [BITS_W-1:0]     blk_cnt_q;
   logic                  done_q;
   logic                  overflow_q;

   logic [BLOCK_W-1:0]    fifo_data [DEPTH];
   logic [BITS_W-1:0]     fifo_bits [DEPTH];
   logic                  fifo_last [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]      count_q;

   logic [31:0]           hdr_next;
   logic                  hdr_last;
   logic [3:0]            hdr_cmd;
   logic [LEN_W-1:0]      hdr_len;
   logic [BLOCK_W-1:0]    blk_next;
   logic [BITS_W-1:0]     cnt_inc;
   logic [TOT_W-1:0]      tot_inc;
   logic                  pay_last;
   logic                  push, pop, push_ok, drop, fifo_full;

`ifdef PMU_PKT_CRC_EN
   logic [31:0]           crc_q, crc_next;
   logic                  crc_err_q;
`endif

   always_comb begin
      hdr_next = {tdi_i, hdr_q[31:1]};
      hdr_last = (hdr_cnt_q == 5'd31);
      hdr_cmd  = hdr_next[3:0];
      hdr_len  = hdr_next[8 +: LEN_W];
      // The first bit of a block starts from an all-zero register, so the
      // unused MSBs of a short final block read back as 0.
      blk_next = (blk_cnt_q == '0) ? '0 : blk_q;
      blk_next[blk_cnt_q[IDX_W-1:0]] = tdi_i;
      cnt_inc  = blk_cnt_q + 1'b1;
      tot_inc  = total_q + 1'b1;
      pay_last = (tot_inc == pay_len_q);
      push     = 1'b0;
      state_d  = state_q;
      case (state_q)
         ST_IDLE: if (shift_en_i) state_d = ST_HDR;
         ST_HDR:  if (shift_en_i && hdr_last) state_d = (hdr_cmd == 4'd0) ? ST_IDLE : ST_PAY;
         ST_PAY: begin
            if (shift_en_i) begin
               push = (cnt_inc == BITS_W'(BLOCK_W)) || pay_last;
`ifdef PMU_PKT_CRC_EN
               if (pay_last) state_d = ST_CRC;
`else
               if (pay_last) state_d = ST_IDLE;
`endif
            end
         end
`ifdef PMU_PKT_CRC_EN
         ST_CRC:  if (shift_en_i && hdr_last) state_d = ST_IDLE;
`endif
         default: state_d = ST_IDLE;
      endcase
      if (abort_i) begin
         state_d = ST_IDLE;
         push    = 1'b0;
      end
   end

   always_comb begin
      fifo_full = (count_q == CNT_W'(DEPTH));
      pop       = (count_q != '0) && blk_ready_i;
      // A full FIFO still accepts a block when the head leaves on the same edge.
      push_ok   = push && (!fifo_full || pop);
      drop      = push && fifo_full && !pop;
   end

`ifdef PMU_PKT_CRC_EN
   always_comb begin
      crc_next = {1'b0, crc_q[31:1]} ^ ((crc_q[0] ^ tdi_i) ? 32'hEDB8_8320 : 32'h0);
   end
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hdr_q       <= '0;
         hdr_cnt_q   <= '0;
         cmd_q       <= '0;
         len_q       <= '0;
         cmd_valid_q <= 1'b0;
         pay_len_q   <= '0;
         total_q     <= '0;
         blk_q       <= '0;
         blk_cnt_q   <= '0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
`ifdef PMU_PKT_CRC_EN
         crc_q       <= '0;
         crc_err_q   <= 1'b0;
`endif
      end else begin
         cmd_valid_q <= 1'b0;
         done_q      <= pop && fifo_last[rd_ptr_q];
         if (drop) overflow_q <= 1'b1;
         if (abort_i) begin
            hdr_cnt_q <= '0;
            blk_cnt_q <= '0;
            total_q   <= '0;
         end else if (shift_en_i) begin
            case (state_q)
               ST_IDLE: begin
                  hdr_q      <= hdr_next;
                  hdr_cnt_q  <= 5'd1;
                  overflow_q <= 1'b0;
`ifdef PMU_PKT_CRC_EN
                  crc_err_q  <= 1'b0;
`endif
               end
               ST_HDR: begin
                  hdr_q     <= hdr_next;
                  hdr_cnt_q <= hdr_cnt_q + 1'b1;
                  if (hdr_last) begin
                     cmd_q       <= hdr_cmd;
                     len_q       <= hdr_len;
                     cmd_valid_q <= 1'b1;
                     pay_len_q   <= (hdr_len == '0) ? TOT_W'(BLOCK_W) : TOT_W'(hdr_len);
                     total_q     <= '0;
                     blk_cnt_q   <= '0;
`ifdef PMU_PKT_CRC_EN
                     crc_q       <= 32'hFFFF_FFFF;
`endif
                  end
               end
               ST_PAY: begin
                  blk_q     <= blk_next;
                  total_q   <= tot_inc;
                  blk_cnt_q <= push ? '0 : cnt_inc;
`ifdef PMU_PKT_CRC_EN
                  crc_q     <= crc_next;
`endif
               end
`ifdef PMU_PKT_CRC_EN
               ST_CRC: begin
                  hdr_q     <= hdr_next;
                  hdr_cnt_q <= hdr_cnt_q + 1'b1;
                  if (hdr_last && (hdr_next != ~crc_q)) crc_err_q <= 1'b1;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_bits[i] <= '0;
            fifo_last[i] <= 1'b0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            fifo_data[wr_ptr_q] <= blk_next;
            fifo_bits[wr_ptr_q] <= cnt_inc;
            fifo_last[wr_ptr_q] <= pay_last;
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign cmd_o       = cmd_q;
   assign len_o       = len_q;
   assign cmd_valid_o = cmd_valid_q;
   assign blk_valid_o = (count_q != '0);
   assign blk_data_o  = fifo_data[rd_ptr_q];
   assign blk_bits_o  = fifo_bits[rd_ptr_q];
   assign blk_last_o  = fifo_last[rd_ptr_q];
   assign busy_o      = (state_q != ST_IDLE) || blk_valid_o;
   assign done_o      = done_q;
   assign overflow_o  = overflow_q;
   assign state_o     = state_q;
`ifdef PMU_PKT_CRC_EN
   assign crc_err_o   = crc_err_q;
`else
   assign crc_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_pmu_pkt_deserializer.sv
// Testbench for pmu_pkt_deserializer: directed packets from the test plan
// plus randomized packets, checked against a block-level reference model.
module tb_pmu_pkt_deserializer;
   localparam int BLOCK_W = 128;
   localparam int DEPTH   = 2;
   localparam int LEN_W   = 24;
   localparam int BITS_W  = $clog2(BLOCK_W) + 1;
   localparam int W       = 1 + BITS_W + BLOCK_W;
   localparam int MAXB    = 1024;

   logic                clk = 1'b0;
   logic                rst_n, shift_en, tdi, abort, blk_ready;
   logic [3:0]          cmd;
   logic [LEN_W-1:0]    len;
   logic                cmd_valid, blk_valid, blk_last, busy, done, overflow, crc_err;
   logic [BLOCK_W-1:0]  blk_data;
   logic [BITS_W-1:0]   blk_bits;
   logic [1:0]          state;

   int                  n_cmp = 0;
   int                  n_err = 0;
   logic [W-1:0]        exp_q[$];
   logic [W-1:0]        mon_e;
   logic                pend_done = 1'b0;
   int                  rdy_mode = 2;   // 0: ready high, 1: random, 2: driven by the test

   logic [127:0]        key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   logic [127:0]        pat  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   logic [MAXB-1:0]     v;
   logic [31:0]         h;

   pmu_pkt_deserializer #(.BLOCK_W(BLOCK_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk_i(clk), .rst_i(rst_n), .shift_en_i(shift_en), .tdi_i(tdi), .abort_i(abort),
      .cmd_o(cmd), .len_o(len), .cmd_valid_o(cmd_valid),
      .blk_data_o(blk_data), .blk_valid_o(blk_valid), .blk_ready_i(blk_ready),
      .blk_last_o(blk_last), .blk_bits_o(blk_bits), .busy_o(busy), .done_o(done),
      .overflow_o(overflow), .crc_err_o(crc_err), .state_o(state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard: popped blocks against the expected queue, done against pops
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (done || pend_done) check("done_pulse", W'(done), W'(pend_done));
            pend_done = 1'b0;
            if (blk_valid && blk_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_blk", {blk_last, blk_bits, blk_data}, '0);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("blk", {blk_last, blk_bits, blk_data}, mon_e);
                  pend_done = mon_e[W-1];
               end
            end
         end
      end
   end

   // consumer ready driver
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rdy_mode == 0)      blk_ready = 1'b1;
         else if (rdy_mode == 1) blk_ready = 1'($urandom_range(0, 1));
      end
   end

   // reference model: split the payload into BLOCK_W chunks
   task automatic model_pkt(input logic [31:0] hd, input logic [MAXB-1:0] pv);
      int eff, nb, bits;
      logic [BLOCK_W-1:0] d, m;
      if (hd[3:0] == 4'd0) return;
      eff = (hd[31:8] == 24'd0) ? BLOCK_W : int'(hd[31:8]);
      nb  = (eff + BLOCK_W - 1) / BLOCK_W;
      for (int i = 0; i < nb; i++) begin
         bits = (eff - i * BLOCK_W > BLOCK_W) ? BLOCK_W : eff - i * BLOCK_W;
         m    = {BLOCK_W{1'b1}} >> (BLOCK_W - bits);
         d    = pv[i * BLOCK_W +: BLOCK_W] & m;
         exp_q.push_back({(i == nb - 1), BITS_W'(bits), d});
      end
   endtask

   // driver tasks
   task automatic gap();
      @(posedge clk); #1;
   endtask

   task automatic shift_bit(input logic b);
      shift_en = 1'b1; tdi = b;
      @(posedge clk); #1;
      shift_en = 1'b0; tdi = 1'b0;
   endtask

   task automatic send_bits(input logic [MAXB-1:0] pv, input int first, input int n, input bit gaps);
      for (int i = first; i < first + n; i++) begin
         if (gaps && $urandom_range(0, 7) == 0) gap();
         shift_bit(pv[i]);
      end
   endtask

   task automatic send_hdr(input logic [31:0] hd, input bit gaps);
      logic [MAXB-1:0] hv;
      hv = '0; hv[31:0] = hd;
      send_bits(hv, 0, 32, gaps);
      check("cmd_valid", W'(cmd_valid), W'(1));
      check("cmd", W'(cmd), W'(hd[3:0]));
      check("len", W'(len), W'(hd[31:8]));
   endtask

`ifdef PMU_PKT_CRC_EN
   function automatic logic [31:0] crc32_of(input logic [MAXB-1:0] pv, input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         if (c[0] ^ pv[i]) c = (c >> 1) ^ 32'hEDB88320;
         else              c = c >> 1;
      end
      return ~c;
   endfunction

   task automatic send_trailer(input logic [31:0] t, input bit gaps);
      logic [MAXB-1:0] tv;
      tv = '0; tv[31:0] = t;
      send_bits(tv, 0, 32, gaps);
   endtask
`endif

   task automatic send_packet(input logic [31:0] hd, input logic [MAXB-1:0] pv, input bit gaps);
      int eff;
      model_pkt(hd, pv);
      send_hdr(hd, gaps);
      if (hd[3:0] != 4'd0) begin
         eff = (hd[31:8] == 24'd0) ? BLOCK_W : int'(hd[31:8]);
         send_bits(pv, 0, eff, gaps);
`ifdef PMU_PKT_CRC_EN
         send_trailer(crc32_of(pv, eff), gaps);
`endif
      end
   endtask

   task automatic wait_drain();
      int budget;
      budget = 2000;
      while ((exp_q.size() != 0 || blk_valid) && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      repeat (2) gap();
      check("drain", W'(exp_q.size()), '0);
   endtask

   task automatic key_load();
      v = '0; v[127:0] = key;
      send_packet(32'h00000005, v, 1'b0);
      wait_drain();
   endtask

   task automatic fill_548();
      v = '0;
      v[511:0]   = {4{pat}};
      v[547:512] = pat[35:0];
   endtask

   initial begin
      rst_n = 1'b0; shift_en = 1'b0; tdi = 1'b0; abort = 1'b0; blk_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_blk_valid", W'(blk_valid), '0);
      check("rst_busy", W'(busy), '0);
      check("rst_cmd_valid", W'(cmd_valid), '0);
      check("rst_cmd_len", W'({cmd, len}), '0);
      check("rst_blk", {blk_last, blk_bits, blk_data}, '0);
      check("rst_flags", W'({done, overflow, crc_err}), '0);
      check("rst_state", W'(state), '0);
      rst_n = 1'b1;
      gap();

      // key load
      rdy_mode = 0;
      key_load();

      // 548-bit bitstream, five blocks
      fill_548();
      send_packet(32'h00022401, v, 1'b0);
      wait_drain();

      // randomized packets with gaps and random backpressure
      rdy_mode = 1;
      repeat (20) begin
         int r;
         r = $urandom_range(0, 9);
         h = '0;
         h[3:0]  = (r == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         h[7:4]  = 4'($urandom);
         h[31:8] = (r == 1) ? 24'd0 : 24'($urandom_range(1, 400));
         for (int j = 0; j < MAXB / 32; j++) v[j * 32 +: 32] = $urandom;
         send_packet(h, v, 1'b1);
         if ($urandom_range(0, 1) == 1) gap();
      end
      rdy_mode = 0;
      wait_drain();
      check("rand_no_overflow", W'(overflow), '0);

      // backpressure: third block of a 384-bit packet is dropped
      rdy_mode = 2; blk_ready = 1'b0;
      gap();
      for (int j = 0; j < MAXB / 32; j++) v[j * 32 +: 32] = $urandom;
      h = 32'h00018003;
      model_pkt(h, v);
      void'(exp_q.pop_back());
      send_hdr(h, 1'b0);
      send_bits(v, 0, 384, 1'b0);
`ifdef PMU_PKT_CRC_EN
      send_trailer(crc32_of(v, 384), 1'b0);
`endif
      check("bp_overflow", W'(overflow), W'(1));
      check("bp_valid", W'(blk_valid), W'(1));
      check("bp_busy", W'(busy), W'(1));
      blk_ready = 1'b1; rdy_mode = 0;
      wait_drain();
      check("bp_overflow_sticky", W'(overflow), W'(1));

      // same packet, ready raised on the cycle block 3 completes
      rdy_mode = 2; blk_ready = 1'b0;
      gap();
      model_pkt(h, v);
      send_hdr(h, 1'b0);
      check("bp2_overflow_clr", W'(overflow), '0);
      send_bits(v, 0, 383, 1'b0);
      blk_ready = 1'b1;
      send_bits(v, 383, 1, 1'b0);
`ifdef PMU_PKT_CRC_EN
      send_trailer(crc32_of(v, 384), 1'b0);
`endif
      rdy_mode = 0;
      wait_drain();
      check("bp2_no_overflow", W'(overflow), '0);

      // abort at payload bit 200: block 1 kept, no done
      rdy_mode = 2; blk_ready = 1'b0;
      gap();
      fill_548();
      h = 32'h00022401;
      model_pkt(h, v);
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      send_hdr(h, 1'b0);
      send_bits(v, 0, 200, 1'b0);
      abort = 1'b1; shift_en = 1'b1; tdi = v[200];
      @(posedge clk); #1;
      abort = 1'b0; shift_en = 1'b0; tdi = 1'b0;
      check("abort_state", W'(state), '0);
      check("abort_valid", W'(blk_valid), W'(1));
      check("abort_busy", W'(busy), W'(1));
      rdy_mode = 0;
      wait_drain();
      key_load();

      // asynchronous reset mid-payload with blocks queued and overflow set
      rdy_mode = 2; blk_ready = 1'b0;
      gap();
      fill_548();
      send_hdr(32'h00022401, 1'b0);
      send_bits(v, 0, 400, 1'b0);
      check("pre_rst_overflow", W'(overflow), W'(1));
      check("pre_rst_valid", W'(blk_valid), W'(1));
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", W'(blk_valid), '0);
      check("arst_busy", W'(busy), '0);
      check("arst_flags", W'({overflow, crc_err, done}), '0);
      check("arst_state", W'(state), '0);
      exp_q.delete();
      pend_done = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      gap();
      rdy_mode = 0;
      key_load();

`ifdef PMU_PKT_CRC_EN
      // CRC-32 check value of "123456789"
      v = '0;
      for (int i = 0; i < 9; i++) v[i * 8 +: 8] = 8'h31 + 8'(i);
      h = 32'h00004802;
      model_pkt(h, v);
      send_hdr(h, 1'b0);
      send_bits(v, 0, 72, 1'b0);
      send_trailer(32'hCBF43926, 1'b0);
      check("crc_good", W'(crc_err), '0);
      wait_drain();
      v[5] = ~v[5];
      model_pkt(h, v);
      send_hdr(h, 1'b0);
      check("crc_clr", W'(crc_err), '0);
      send_bits(v, 0, 72, 1'b0);
      send_trailer(32'hCBF43926, 1'b0);
      check("crc_bad", W'(crc_err), W'(1));
      wait_drain();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
